// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port driver: widths, command/response codes
// and the driver state encoding.
package calc1_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;

    typedef logic [0:CMD_W-1]  cmd_t;
    typedef logic [0:DATA_W-1] data_t;
    typedef logic [0:RESP_W-1] resp_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE    = 2'd0;
    localparam resp_t RESP_OK      = 2'd1;
    localparam resp_t RESP_ERR     = 2'd2;
    localparam resp_t RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/calc1_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module calc1_wait_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/calc1_port_driver.sv
// Sequences one calc1 port: accepts an operation, drives the two-cycle request,
// waits (with timeout) for the response and holds the result until consumed.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             c_clk,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [0:3]       op_cmd,
    input  logic [0:31]      op_data1,
    input  logic [0:31]      op_data2,
    output logic [0:3]       req_cmd_out,
    output logic [0:31]      req_data_out,
    input  logic [0:1]       calc_resp,
    input  logic [0:31]      calc_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [0:1]       res_resp,
    output logic [0:31]      res_data,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t           state_d, state_q;
    logic             op_ready_d, op_ready_q;
    logic             res_valid_d, res_valid_q;
    cmd_t             req_cmd_d, req_cmd_q;
    data_t            req_data_d, req_data_q;
    data_t            op_data2_d, op_data2_q;
    resp_t            res_resp_d, res_resp_q;
    data_t            res_data_d, res_data_q;
    logic [CNT_W-1:0] issue_cnt_d, issue_cnt_q;
    logic [CNT_W-1:0] timeout_cnt_d, timeout_cnt_q;
    logic             tmr_expired;

    // Loaded with TIMEOUT-1 on the way into WAIT, so expiry is seen on the
    // TIMEOUT-th WAIT edge.
    calc1_wait_timer #(
        .WIDTH (TMR_W)
    ) u_wait_timer (
        .clk      (c_clk),
        .reset_n  (reset_n),
        .load     (state_q == ST_SEND2),
        .load_val (TMR_W'(TIMEOUT - 1)),
        .en       (state_q == ST_WAIT),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        op_data2_d    = op_data2_q;
        req_cmd_d     = '0;
        req_data_d    = '0;
        res_resp_d    = res_resp_q;
        res_data_d    = res_data_q;
        issue_cnt_d   = issue_cnt_q;
        timeout_cnt_d = timeout_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid && op_ready_q) begin
                    state_d    = ST_SEND1;
                    op_data2_d = op_data2;
                    req_cmd_d  = op_cmd;
                    req_data_d = op_data1;
                end
            end
            ST_SEND1: begin
                state_d     = ST_SEND2;
                req_data_d  = op_data2_q;
                issue_cnt_d = issue_cnt_q + 1'b1;
            end
            ST_SEND2: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response on the expiry edge takes precedence over the timeout.
                if (calc_resp != RESP_NONE) begin
                    state_d    = ST_DONE;
                    res_resp_d = calc_resp;
                    res_data_d = calc_data;
                end else if (tmr_expired) begin
                    state_d       = ST_DONE;
                    res_resp_d    = RESP_TIMEOUT;
                    res_data_d    = '0;
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        op_ready_d  = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            op_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            req_cmd_q     <= '0;
            req_data_q    <= '0;
            op_data2_q    <= '0;
            res_resp_q    <= '0;
            res_data_q    <= '0;
            issue_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            op_ready_q    <= op_ready_d;
            res_valid_q   <= res_valid_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            op_data2_q    <= op_data2_d;
            res_resp_q    <= res_resp_d;
            res_data_q    <= res_data_d;
            issue_cnt_q   <= issue_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign res_valid    = res_valid_q;
    assign req_cmd_out  = req_cmd_q;
    assign req_data_out = req_data_q;
    assign res_resp     = res_resp_q;
    assign res_data     = res_data_q;
    assign issue_cnt    = issue_cnt_q;
    assign timeout_cnt  = timeout_cnt_q;

endmodule
